// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and its consumers.
//   master (generator): takes enable; drives pix_ce, vga_clk, vga_hs, vga_vs, vga_blank_n,
//   counth, countv, frame_cnt, line_start, frame_start
//   (plus next_h, next_v, next_active when VGA_TIMING_LOOKAHEAD_EN is defined).
//   slave (renderer/DAC side): mirror image.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 8
);
  logic               enable;
  logic               pix_ce;
  logic               vga_clk;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank_n;
  logic [CNT_W-1:0]   counth;
  logic [CNT_W-1:0]   countv;
  logic [FRAME_W-1:0] frame_cnt;
  logic               line_start;
  logic               frame_start;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [CNT_W-1:0]   next_h;
  logic [CNT_W-1:0]   next_v;
  logic               next_active;
  modport master (input enable, output pix_ce, vga_clk, vga_hs, vga_vs, vga_blank_n, counth, countv,
                  frame_cnt, line_start, frame_start, next_h, next_v, next_active);
  modport slave (output enable, input pix_ce, vga_clk, vga_hs, vga_vs, vga_blank_n, counth, countv,
                 frame_cnt, line_start, frame_start, next_h, next_v, next_active);
`else
  modport master (input enable, output pix_ce, vga_clk, vga_hs, vga_vs, vga_blank_n, counth, countv,
                  frame_cnt, line_start, frame_start);
  modport slave (output enable, input pix_ce, vga_clk, vga_hs, vga_vs, vga_blank_n, counth, countv,
                 frame_cnt, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator driven from one system clock.
//   clk, rst_n (async active-low); bus (vga_timing_gen_if.master): enable in; pixel enable,
//   DAC pixel clock, syncs, blank, coordinates, frame count and line/frame strobes out.
//   Optional VGA_TIMING_LOOKAHEAD_EN adds next_h/next_v/next_active on the bus.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0 || CLK_DIV < 2) begin : g_bad_params
    $error("vga_timing_gen: totals must fit CNT_W and CLK_DIV must be >= 2");
  end
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_ON    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_OFF   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_ON    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_OFF   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] h, v, h_inc, v_inc;
  logic             h_wrap, v_wrap, hs_act, vs_act, pix_ce_d, run;
  always_comb begin
    div_nxt = !bus.enable || div_cnt == DIV_MAX ? '0 : div_cnt + DIV_W'(1);
    h_wrap  = h == H_MAX;
    v_wrap  = v == V_MAX;
    h_inc   = h_wrap ? '0 : h + CNT_W'(1);
    v_inc   = !h_wrap ? v : v_wrap ? '0 : v + CNT_W'(1);
    hs_act  = h >= HS_ON && h < HS_OFF;
    vs_act  = v >= VS_ON && v < VS_OFF;
  end
  // pix_ce_d marks the clk in which the output stage first sees a freshly advanced h/v;
  // run is low on the first enabled clk after reset/park so (0,0) still raises the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt         <= '0;
      h               <= '0;
      v               <= '0;
      pix_ce_d        <= 1'b0;
      run             <= 1'b0;
      bus.pix_ce      <= 1'b0;
      bus.vga_clk     <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.counth      <= '0;
      bus.countv      <= '0;
      bus.vga_hs      <= !HS_POL;
      bus.vga_vs      <= !VS_POL;
      bus.vga_blank_n <= 1'b0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
`ifdef VGA_TIMING_LOOKAHEAD_EN
      bus.next_h      <= '0;
      bus.next_v      <= '0;
      bus.next_active <= 1'b1;
`endif
    end else begin
      div_cnt         <= div_nxt;
      bus.pix_ce      <= bus.enable && div_nxt == DIV_MAX;
      bus.vga_clk     <= bus.enable && div_nxt >= DIV_HALF;
      pix_ce_d        <= bus.enable && bus.pix_ce;
      run             <= bus.enable;
      h               <= !bus.enable ? '0 : bus.pix_ce ? h_inc : h;
      v               <= !bus.enable ? '0 : bus.pix_ce ? v_inc : v;
      bus.frame_cnt   <= bus.frame_cnt + FRAME_W'(bus.enable && bus.pix_ce && h_wrap && v_wrap);
      bus.counth      <= bus.enable ? h : '0;
      bus.countv      <= bus.enable ? v : '0;
      bus.vga_hs      <= bus.enable && hs_act ? HS_POL : !HS_POL;
      bus.vga_vs      <= bus.enable && vs_act ? VS_POL : !VS_POL;
      bus.vga_blank_n <= bus.enable && h < H_ACT && v < V_ACT;
      bus.line_start  <= bus.enable && (!run || (pix_ce_d && h == '0));
      bus.frame_start <= bus.enable && (!run || (pix_ce_d && h == '0 && v == '0));
`ifdef VGA_TIMING_LOOKAHEAD_EN
      bus.next_h      <= bus.enable ? h_inc : '0;
      bus.next_v      <= bus.enable ? v_inc : '0;
      bus.next_active <= !bus.enable || (h_inc < H_ACT && v_inc < V_ACT);
`endif
    end
  end
endmodule
